// File: rtl/i2s_in_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_in_pkg
//  Description : Shared I2S definitions: channel width default, word-select
//                polarity and deserializer state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_in_pkg;

    // Bits per channel shared by the input and output paths
    localparam int   c_ch_width = 16;

    // Word-select level that marks the left channel
    localparam logic c_ws_left  = 1'b0;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } deser_state_e;

endpackage : i2s_in_pkg
`default_nettype wire

// File: rtl/i2s_in_deser.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_in_deser
//  Description : I2S deserializer. Captures MSB-first left/right words on SCK
//                pulses and emits a one-clock strobe carrying {left,right}
//                once the right word is closed by a WS falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_in_deser
    import i2s_in_pkg::*;
#(
    parameter int CH_WIDTH = c_ch_width
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sck_transition,
    input  logic                ws,
    input  logic                sd,
    output logic [CH_WIDTH-1:0] i2si_deser_lft,
    output logic [CH_WIDTH-1:0] i2si_deser_rgt,
    output logic                i2si_deser_rts
);

    localparam int                CNT_W = $clog2(CH_WIDTH + 1);
    localparam logic [CH_WIDTH-1:0] c_one = CH_WIDTH'(1);

    deser_state_e          r_state, w_state_nxt;
    logic                  r_ws_q;
    logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [CH_WIDTH-1:0]   r_left_sr, w_left_sr_nxt;
    logic [CH_WIDTH-1:0]   r_right_sr, w_right_sr_nxt;
    logic [CH_WIDTH-1:0]   r_out_lft, w_out_lft_nxt;
    logic [CH_WIDTH-1:0]   r_out_rgt, w_out_rgt_nxt;
    logic                  r_push, w_push_nxt;

    logic                  w_ws_edge;
    logic                  w_can_cap;
    logic [CH_WIDTH-1:0]   w_sd_bit;

    // A WS edge only exists in a cycle that carries an SCK pulse
    assign w_ws_edge = sck_transition && (ws != r_ws_q);
    // Bits past the channel width are dropped; counter saturates at CH_WIDTH
    assign w_can_cap = (r_bit_cnt < CNT_W'(CH_WIDTH));
    // Slot for the current bit, MSB first; only meaningful while w_can_cap
    assign w_sd_bit  = sd ? (c_one << (CNT_W'(CH_WIDTH - 1) - r_bit_cnt)) : '0;

    // State, counters, shift registers and output strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SYNC;
            r_ws_q     <= 1'b0;
            r_bit_cnt  <= '0;
            r_left_sr  <= '0;
            r_right_sr <= '0;
            r_out_lft  <= '0;
            r_out_rgt  <= '0;
            r_push     <= 1'b0;
        end else begin
            if (sck_transition) begin
                r_ws_q <= ws;
            end
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_left_sr  <= w_left_sr_nxt;
            r_right_sr <= w_right_sr_nxt;
            r_out_lft  <= w_out_lft_nxt;
            r_out_rgt  <= w_out_rgt_nxt;
            r_push     <= w_push_nxt;
        end
    end

    // Next-state and capture logic; the WS-edge pulse still carries the LSB
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_left_sr_nxt  = r_left_sr;
        w_right_sr_nxt = r_right_sr;
        w_out_lft_nxt  = r_out_lft;
        w_out_rgt_nxt  = r_out_rgt;
        w_push_nxt     = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_ws_edge && (ws == c_ws_left)) begin
                    w_state_nxt   = ST_LEFT;
                    w_bit_cnt_nxt = '0;
                    w_left_sr_nxt = '0;
                end
            end
            ST_LEFT: begin
                if (sck_transition) begin
                    if (w_can_cap) begin
                        w_left_sr_nxt = r_left_sr | w_sd_bit;
                    end
                    if (w_ws_edge) begin
                        w_state_nxt    = ST_RIGHT;
                        w_bit_cnt_nxt  = '0;
                        w_right_sr_nxt = '0;
                    end else if (w_can_cap) begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            ST_RIGHT: begin
                if (sck_transition) begin
                    if (w_can_cap) begin
                        w_right_sr_nxt = r_right_sr | w_sd_bit;
                    end
                    if (w_ws_edge) begin
                        w_out_lft_nxt = r_left_sr;
                        w_out_rgt_nxt = w_right_sr_nxt;
                        w_push_nxt    = 1'b1;
                        w_state_nxt   = ST_LEFT;
                        w_bit_cnt_nxt = '0;
                        w_left_sr_nxt = '0;
                    end else if (w_can_cap) begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    assign i2si_deser_lft = r_out_lft;
    assign i2si_deser_rgt = r_out_rgt;
    assign i2si_deser_rts = r_push;

endmodule : i2s_in_deser
`default_nettype wire

// File: rtl/i2s_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_in_fifo
//  Description : Synchronous rts/rtr FIFO. Input rtr reflects the current
//                fill level only (no look-ahead on a same-cycle pop).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_in_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_rts,
    output logic             in_rtr,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_rts,
    input  logic             out_rtr,
    output logic [WIDTH-1:0] out_data
);

    localparam int c_depth = 2 ** AW;

    logic [WIDTH-1:0] r_mem [c_depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign in_rtr   = (r_count != (AW+1)'(c_depth));
    assign out_rts  = (r_count != '0);
    // Data is forced to zero while empty so the port reads 0 out of reset
    assign out_data = out_rts ? r_mem[r_rd_ptr] : '0;
    assign w_push   = in_rts && in_rtr;
    assign w_pop    = out_rts && out_rtr;

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : i2s_in_fifo
`default_nettype wire

// File: rtl/i2s_in.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_in
//  Description : I2S receive front end. Deserializes stereo audio, buffers
//                {left,right} words in a FIFO toward the filter and flags
//                frames dropped because the FIFO was full.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_in
    import i2s_in_pkg::*;
#(
    parameter int CH_WIDTH = c_ch_width,
    parameter int FIFO_AW  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i2si_sck_transition,
    input  logic                  i2si_ws,
    input  logic                  i2si_sd,
    output logic                  i2si_rts,
    input  logic                  i2si_rtr,
    output logic [2*CH_WIDTH-1:0] i2si_data,
    input  logic                  trig_fifo_overrun,
    output logic                  ro_fifo_overrun
);

    logic [CH_WIDTH-1:0] w_deser_lft;
    logic [CH_WIDTH-1:0] w_deser_rgt;
    logic                w_deser_rts;
    logic                w_fifo_in_rtr;
    logic                r_overrun;

    i2s_in_deser #(
        .CH_WIDTH (CH_WIDTH)
    ) u_deser (
        .clk            (clk),
        .rst_n          (rst_n),
        .sck_transition (i2si_sck_transition),
        .ws             (i2si_ws),
        .sd             (i2si_sd),
        .i2si_deser_lft (w_deser_lft),
        .i2si_deser_rgt (w_deser_rgt),
        .i2si_deser_rts (w_deser_rts)
    );

    i2s_in_fifo #(
        .WIDTH (2 * CH_WIDTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_rts   (w_deser_rts),
        .in_rtr   (w_fifo_in_rtr),
        .in_data  ({w_deser_lft, w_deser_rgt}),
        .out_rts  (i2si_rts),
        .out_rtr  (i2si_rtr),
        .out_data (i2si_data)
    );

    // Sticky drop flag: a dropped frame wins over a same-cycle clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_deser_rts && !w_fifo_in_rtr) begin
            r_overrun <= 1'b1;
        end else if (trig_fifo_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign ro_fifo_overrun = r_overrun;

endmodule : i2s_in
`default_nettype wire

// File: tb/tb_i2s_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_in
//  Description : Self-checking bench for i2s_in: generates I2S serial frames,
//                predicts captured words from channel contents and compares
//                the words handed out on the rts/rtr port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_in;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        rtr;
    logic        trig;
    logic        rts;
    logic [31:0] data;
    logic        ovr;

    int total = 0;
    int bad   = 0;
    int gap   = 1;

    logic [31:0] got_q[$];

    i2s_in dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i2si_sck_transition (sck),
        .i2si_ws             (ws),
        .i2si_sd             (sd),
        .i2si_rts            (rts),
        .i2si_rtr            (rtr),
        .i2si_data           (data),
        .trig_fifo_overrun   (trig),
        .ro_fifo_overrun     (ovr)
    );

    always #5 clk = ~clk;

    // Record every word that leaves the block (transfer at the next rising edge)
    always @(negedge clk) begin
        if (rst_n && rts && rtr) got_q.push_back(data);
    end

    // Expected capture of one channel: first 16 transmitted bits, left-justified
    function automatic logic [15:0] ch_model(input logic [63:0] v, input int p);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i < p) r[15-i] = v[p-1-i];
        return r;
    endfunction

    task automatic pulse(input logic w, input logic d, input bit trig_here);
        @(posedge clk); #1;
        ws = w; sd = d; sck = 1'b1;
        @(posedge clk); #1;
        sck = 1'b0;
        if (trig_here) begin
            trig = 1'b1;
            @(posedge clk); #1;
            trig = 1'b0;
        end
        repeat (gap) @(posedge clk);
    endtask

    // Standard I2S: WS for the next channel changes on this channel's last bit
    task automatic send_channel(input logic w_this, input logic w_next, input int p,
                                input logic [63:0] v, input bit trig_end);
        for (int s = 0; s < p; s++)
            pulse((s == p-1) ? w_next : w_this, v[p-1-s], (s == p-1) && trig_end);
    endtask

    task automatic send_frame(input logic [63:0] vl, input int pl, input logic [63:0] vr,
                              input int pr, input bit trig_end, output logic [31:0] expw);
        send_channel(1'b0, 1'b1, pl, vl, 1'b0);
        send_channel(1'b1, 1'b0, pr, vr, trig_end);
        expw = {ch_model(vl, pl), ch_model(vr, pr)};
    endtask

    task automatic preamble();
        send_channel(1'b1, 1'b0, 4, 64'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; trig = 1'b0; rtr = 1'b1; gap = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        @(posedge clk);
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(posedge clk);
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; trig = 1'b0; rtr = 1'b0;
        repeat (2) @(posedge clk); #1;
        total++; if (rts !== 1'b0) begin bad++; $display("FAIL reset_rts got=%b want=0", rts); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", ovr); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        total++; if (rts !== 1'b0) begin bad++; $display("FAIL idle_rts got=%b want=0", rts); end
    endtask

    task automatic test_basic();
        logic [31:0] e;
        do_reset();
        preamble();
        send_frame(64'hA5C3, 16, 64'h1234, 16, 1'b0, e);
        wait_drain(1);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", got_q.size()); end
        total++; if (got_q.size() < 1 || got_q[0] !== e) begin bad++;
            $display("FAIL basic_word got=%h want=%h", (got_q.size() > 0) ? got_q[0] : 32'hx, e); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL basic_ovr got=%b want=0", ovr); end
    endtask

    task automatic test_mid_right();
        logic [31:0] e[2];
        do_reset();
        send_channel(1'b1, 1'b0, 7, 64'($urandom), 1'b0);
        for (int k = 0; k < 2; k++)
            send_frame(64'($urandom_range(0, 65535)), 16, 64'($urandom_range(0, 65535)), 16, 1'b0, e[k]);
        wait_drain(2);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL midright_count got=%0d want=2", got_q.size()); end
        for (int k = 0; k < 2; k++) begin
            total++; if (got_q.size() <= k || got_q[k] !== e[k]) begin bad++;
                $display("FAIL midright_word%0d got=%h want=%h", k, (got_q.size() > k) ? got_q[k] : 32'hx, e[k]); end
        end
    endtask

    task automatic test_long_words();
        logic [31:0] e;
        do_reset();
        preamble();
        send_frame(64'hFFFF_0000, 32, 64'h0001_0000, 32, 1'b0, e);
        wait_drain(1);
        total++; if (got_q.size() != 1 || got_q[0] !== e) begin bad++;
            $display("FAIL long_word n=%0d got=%h want=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, e); end
    endtask

    task automatic test_short_words();
        logic [31:0] e;
        do_reset();
        preamble();
        send_frame(64'hFF, 8, 64'h80, 8, 1'b0, e);
        wait_drain(1);
        total++; if (got_q.size() != 1 || got_q[0] !== e) begin bad++;
            $display("FAIL short_word n=%0d got=%h want=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, e); end
    endtask

    task automatic test_overrun();
        logic [31:0] e;
        logic [31:0] model_q[$];
        bit          exp_ovr;
        do_reset();
        rtr = 1'b0;
        exp_ovr = 1'b0;
        preamble();
        for (int k = 1; k <= 9; k++) begin
            send_frame(64'(k), 16, 64'(k), 16, 1'b0, e);
            if (model_q.size() < 8) model_q.push_back(e); else exp_ovr = 1'b1;
            repeat (2) @(posedge clk); #1;
            if (k >= 8) begin
                total++; if (ovr !== exp_ovr) begin bad++; $display("FAIL ovr_after_frame%0d got=%b want=%b", k, ovr, exp_ovr); end
            end
        end
        // Head word must hold while the consumer stalls
        for (int i = 0; i < 2; i++) begin
            repeat (3) @(posedge clk); #1;
            total++; if (rts !== 1'b1 || data !== model_q[0]) begin bad++;
                $display("FAIL stall_hold rts=%b got=%h want=%h", rts, data, model_q[0]); end
        end
        rtr = 1'b1;
        wait_drain(8);
        total++; if (got_q.size() != model_q.size()) begin bad++;
            $display("FAIL drain_count got=%0d want=%0d", got_q.size(), model_q.size()); end
        for (int k = 0; k < model_q.size(); k++) begin
            total++; if (got_q.size() <= k || got_q[k] !== model_q[k]) begin bad++;
                $display("FAIL drain_word%0d got=%h want=%h", k, (got_q.size() > k) ? got_q[k] : 32'hx, model_q[k]); end
        end
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", ovr); end
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", ovr); end
        // Refill, then drop the ninth frame in the same cycle as a clear request
        rtr = 1'b0;
        for (int k = 0; k < 8; k++) send_frame(64'($urandom), 16, 64'($urandom), 16, 1'b0, e);
        repeat (2) @(posedge clk); #1;
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_full_nodrop got=%b want=0", ovr); end
        send_frame(64'($urandom), 16, 64'($urandom), 16, 1'b1, e);
        repeat (2) @(posedge clk); #1;
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set_priority got=%b want=1", ovr); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        do_reset();
        preamble();
        send_channel(1'b0, 1'b1, 16, 64'($urandom), 1'b0);
        send_channel(1'b1, 1'b1, 8, 64'($urandom), 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        total++; if (rts !== 1'b0 || ovr !== 1'b0) begin bad++;
            $display("FAIL midreset_in rts=%b ovr=%b want=0/0", rts, ovr); end
        rst_n = 1'b1;
        got_q.delete();
        preamble();
        send_channel(1'b0, 1'b1, 16, 64'h0F0F, 1'b0);
        total++; if (rts !== 1'b0 || ovr !== 1'b0) begin bad++;
            $display("FAIL midreset_after rts=%b ovr=%b want=0/0", rts, ovr); end
        send_channel(1'b1, 1'b0, 16, 64'hF0F0, 1'b0);
        e = {ch_model(64'h0F0F, 16), ch_model(64'hF0F0, 16)};
        wait_drain(1);
        total++; if (got_q.size() != 1 || got_q[0] !== e) begin bad++;
            $display("FAIL midreset_word n=%0d got=%h want=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, e); end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        bit          done;
        do_reset();
        done = 1'b0;
        preamble();
        fork
            begin
                logic [31:0] e;
                for (int k = 0; k < 12; k++) begin
                    gap = $urandom_range(0, 3);
                    send_frame({$urandom, $urandom}, $urandom_range(4, 32),
                               {$urandom, $urandom}, $urandom_range(4, 32), 1'b0, e);
                    exp_q.push_back(e);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rtr = 1'($urandom_range(0, 1));
                end
            end
        join
        rtr = 1'b1;
        gap = 1;
        wait_drain(exp_q.size());
        total++; if (got_q.size() != exp_q.size()) begin bad++;
            $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            total++; if (got_q.size() <= k || got_q[k] !== exp_q[k]) begin bad++;
                $display("FAIL rand_word%0d got=%h want=%h", k, (got_q.size() > k) ? got_q[k] : 32'hx, exp_q[k]); end
        end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL rand_ovr got=%b want=0", ovr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_right();
        test_long_words();
        test_overrun();
        test_short_words();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_i2s_in
`default_nettype wire
